video_in_pack: RTL



---
 rtl/video_in_pack.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/video_in_pack.sv
`default_nettype none
// ============================================================================
// video_in_pack : packs four 8-bit pixels per 32-bit word into a FWFT FIFO,
//                 capturing exactly one frame per new_addr pulse.
// Revision 1.0
// ============================================================================
module video_in_pack #(
    parameter int p_WIDTH       = 640,
    parameter int p_HEIGHT      = 480,
    parameter int NB_PACK_STORE = 16,
    parameter int FIFO_DEPTH    = 64
) (
    input  logic                          clk,
    input  logic                          nRST,
    input  logic                          new_addr,
    input  logic [7:0]                    pixel_in,
    input  logic                          line_valid,
    input  logic                          frame_valid,
    input  logic                          r_ack,
    output logic [31:0]                   data_fifo,
    output logic                          nb_pack_available,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          capturing
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [18:0]     TOTAL_PIX = 19'(p_WIDTH * p_HEIGHT);
    localparam logic [AW:0]     DEPTH_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]     NB_LVL    = (AW + 1)'(NB_PACK_STORE);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t         state, state_next;
    logic           fv_prev;
    logic           take_pixel;
    logic [1:0]     lane;
    logic [23:0]    pack;
    logic [31:0]    push_word;
    logic           push_pend;
    logic [18:0]    pix_cnt;
    logic [31:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           fifo_full, fifo_empty, do_pop, do_push;

    assign fifo_full  = (fifo_level == DEPTH_LVL);
    assign fifo_empty = (fifo_level == '0);
    assign do_pop     = r_ack && !fifo_empty;
    // A pop in the same cycle frees the slot the pending word needs.
    assign do_push    = push_pend && (!fifo_full || do_pop);

    always_comb begin
        state_next = state;
        take_pixel = 1'b0;
        if (new_addr) begin
            state_next = WAIT_FRAME;
        end else begin
            case (state)
                WAIT_FRAME: begin
                    if (frame_valid && !fv_prev) begin
                        state_next = CAPTURE;
                        take_pixel = line_valid;
                    end
                end
                CAPTURE:    take_pixel = line_valid && frame_valid;
                default:    ;
            endcase
            if (take_pixel && (pix_cnt + 19'd1 == TOTAL_PIX))
                state_next = DONE;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            fv_prev <= 1'b0;
        end else begin
            state   <= state_next;
            fv_prev <= frame_valid;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            lane       <= 2'd0;
            pack       <= 24'd0;
            push_word  <= 32'd0;
            push_pend  <= 1'b0;
            pix_cnt    <= 19'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else if (new_addr) begin
            lane       <= 2'd0;
            push_pend  <= 1'b0;
            pix_cnt    <= 19'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            push_pend <= take_pixel && (lane == 2'd3);
            if (take_pixel) begin
                pix_cnt <= pix_cnt + 19'd1;
                lane    <= lane + 2'd1;
                case (lane)
                    2'd0:    pack[7:0]   <= pixel_in;
                    2'd1:    pack[15:8]  <= pixel_in;
                    2'd2:    pack[23:16] <= pixel_in;
                    default: push_word   <= {pixel_in, pack};
                endcase
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_push && !do_pop)
                fifo_level <= fifo_level + 1'b1;
            else if (do_pop && !do_push)
                fifo_level <= fifo_level - 1'b1;
            if (push_pend && !do_push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !new_addr)
            mem[wr_ptr] <= push_word;
    end

    assign data_fifo         = fifo_empty ? 32'd0 : mem[rd_ptr];
    assign nb_pack_available = (fifo_level >= NB_LVL);
    assign capturing         = (state == CAPTURE);

endmodule
`default_nettype wire
